// File: rtl/bidir_io_ctrl_pkg.sv
// rtl/bidir_io_ctrl_pkg.sv - shared register selects and prime-state type
//
// Purpose: register-select codes decoded from addr[top:WordBits] and the
// post-reset priming state machine encoding used by bidir_io_ctrl.
package bidir_io_ctrl_pkg;

  localparam logic [2:0] REG_DATA      = 3'd0;
  localparam logic [2:0] REG_DDR       = 3'd1;
  localparam logic [2:0] REG_OD        = 3'd2;
  localparam logic [2:0] REG_EDGE_STAT = 3'd3;
  localparam logic [2:0] REG_EDGE_MASK = 3'd4;

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    PRIME2 = 2'd2,
    RUN    = 2'd3
  } prime_state_e;

endpackage

// File: rtl/bidir_io_ctrl_sync.sv
// rtl/bidir_io_ctrl_sync.sv - pin read-back synchroniser with edge detect
//
// Purpose: brings the asynchronous pin state into the clk domain through two
// flops (s1, s2) and keeps one history flop (s3) for edge detection.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   data_i   in   raw pin state (asynchronous)
//   sync_o   out  synchronised pin state (s2)
//   edge_o   out  per-pin change flag, rising or falling (s2 ^ s3)
module io_input_sync #(
  parameter int Width = 36
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] sync_o,
  output logic [Width-1:0] edge_o
);

  logic [Width-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= data_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/bidir_io_ctrl.sv
// rtl/bidir_io_ctrl.sv - bus-mapped controller for a bidirectional pin bank
//
// Purpose: register file (DATA, DDR, OD, EDGE_STAT, EDGE_MASK) that drives the
// pin-driver inputs, samples the pins, latches edges and raises an interrupt.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   addr           {reg_sel[2:0], word[WordBits-1:0]}
//   wr_en/wr_data  single-cycle write strobe and data
//   rd_en          single-cycle read strobe
//   rd_data        registered read data, held until the next read
//   rd_valid       one-cycle pulse, the cycle after rd_en
//   oe/od/out_data per-pin output enable, open-drain select, output value
//   read_data      raw pin state from the pin driver (asynchronous)
//   irq            registered interrupt, |(EDGE_STAT & EDGE_MASK)
module bidir_io_ctrl
  import bidir_io_ctrl_pkg::*;
#(
  parameter int IOWidth  = 36,
  parameter int WordBits = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3+WordBits-1:0] addr,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [IOWidth-1:0]    oe,
  output logic [IOWidth-1:0]    od,
  output logic [IOWidth-1:0]    out_data,
  input  logic [IOWidth-1:0]    read_data,
  output logic                  irq
);

  localparam int NWords = (IOWidth + 31) / 32;

  logic [2:0]          reg_sel;
  logic [WordBits-1:0] word;
  assign reg_sel = addr[WordBits+2:WordBits];
  assign word    = addr[WordBits-1:0];

  logic [IOWidth-1:0] out_q, out_d;
  logic [IOWidth-1:0] oe_q, oe_d;
  logic [IOWidth-1:0] od_q, od_d;
  logic [IOWidth-1:0] stat_q, stat_d;
  logic [IOWidth-1:0] mask_q, mask_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q;
  logic               irq_q, irq_d;
  prime_state_e       state_q, state_d;

  logic [IOWidth-1:0] sync_w, edge_w;

  io_input_sync #(.Width(IOWidth)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (read_data),
    .sync_o  (sync_w),
    .edge_o  (edge_w)
  );

  // Per-pin view of the addressed word. A word index >= NWords matches no pin,
  // and bits above IOWidth have no pin, so both drop out naturally here.
  logic [IOWidth-1:0] word_hit;
  logic [IOWidth-1:0] wdata_pins;
  always_comb begin
    word_hit   = '0;
    wdata_pins = '0;
    for (int i = 0; i < IOWidth; i++) begin
      word_hit[i]   = (int'(word) == i / 32);
      wdata_pins[i] = wr_data[i % 32];
    end
  end

  logic [IOWidth-1:0] wbits;
  assign wbits = wdata_pins & word_hit;

  logic [IOWidth-1:0] w1c;
  logic [IOWidth-1:0] edge_set;

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    od_d   = od_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_DATA:      out_d  = (out_q  & ~word_hit) | wbits;
        REG_DDR:       oe_d   = (oe_q   & ~word_hit) | wbits;
        REG_OD:        od_d   = (od_q   & ~word_hit) | wbits;
        REG_EDGE_STAT: w1c    = wbits;
        REG_EDGE_MASK: mask_d = (mask_q & ~word_hit) | wbits;
        default:       ;
      endcase
    end
    // Edges are ignored while priming so pins already high at reset release
    // do not show up as status. The set term is ORed last so it beats a W1C.
    edge_set = (state_q == RUN) ? edge_w : '0;
    stat_d   = (stat_q & ~w1c) | edge_set;
    irq_d    = |(stat_d & mask_d);
  end

  // Read mux uses current (pre-write) register values.
  logic [IOWidth-1:0] rd_src;
  logic [31:0]        rd_word;
  always_comb begin
    case (reg_sel)
      REG_DATA:      rd_src = sync_w;
      REG_DDR:       rd_src = oe_q;
      REG_OD:        rd_src = od_q;
      REG_EDGE_STAT: rd_src = stat_q;
      REG_EDGE_MASK: rd_src = mask_q;
      default:       rd_src = '0;
    endcase
    rd_word = '0;
    for (int i = 0; i < IOWidth; i++) begin
      if (word_hit[i]) rd_word[i % 32] = rd_src[i];
    end
    rd_data_d = rd_en ? rd_word : rd_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME0:  state_d = PRIME1;
      PRIME1:  state_d = PRIME2;
      PRIME2:  state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      oe_q       <= '0;
      od_q       <= '0;
      stat_q     <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= PRIME0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      od_q       <= od_d;
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  assign out_data = out_q;
  assign oe       = oe_q;
  assign od       = od_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

  // NWords is only referenced for documentation of the word range.
  logic unused_nwords;
  assign unused_nwords = (NWords > (1 << WordBits));

endmodule

// File: tb/tb_bidir_io_ctrl.sv
// tb/tb_bidir_io_ctrl.sv - directed self-checking bench for bidir_io_ctrl
module tb_bidir_io_ctrl;

  localparam int IOWidth  = 36;
  localparam int WordBits = 3;

  localparam logic [2:0] S_DATA = 3'd0;
  localparam logic [2:0] S_DDR  = 3'd1;
  localparam logic [2:0] S_OD   = 3'd2;
  localparam logic [2:0] S_STAT = 3'd3;
  localparam logic [2:0] S_MASK = 3'd4;
  localparam logic [2:0] S_RSVD = 3'd6;

  logic                  clk;
  logic                  reset_n;
  logic [3+WordBits-1:0] addr;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  rd_en;
  logic [31:0]           rd_data;
  logic                  rd_valid;
  logic [IOWidth-1:0]    oe;
  logic [IOWidth-1:0]    od;
  logic [IOWidth-1:0]    out_data;
  logic [IOWidth-1:0]    read_data;
  logic                  irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  bidir_io_ctrl #(.IOWidth(IOWidth), .WordBits(WordBits)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .oe        (oe),
    .od        (od),
    .out_data  (out_data),
    .read_data (read_data),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read results are popped from the scoreboard whenever rd_valid is seen.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL rd_unexpected: observed rd_valid with rd_data 0x%0h expected no read", rd_data);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        n_tests++;
        assert (rd_data === exp) else begin
          n_fail++;
          $error("FAIL rd_data: observed 0x%08h expected 0x%08h", rd_data, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [2:0] w, input logic [31:0] d);
    addr    = {sel, w};
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [2:0] w, input logic [31:0] exp);
    addr  = {sel, w};
    rd_en = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] sel, input logic [2:0] w, input logic [31:0] d,
                      input logic [31:0] exp);
    addr    = {sel, w};
    wr_data = d;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    addr      = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_en     = 1'b0;
    read_data = '1;

    // Reset defaults with all pins high
    tick(3);
    chk("rst_oe_held", oe, 0);
    reset_n = 1'b1;
    chk("rst_oe", oe, 0);
    chk("rst_od", od, 0);
    chk("rst_out", out_data, 0);
    chk("rst_irq", irq, 0);
    tick(5);
    rd(S_STAT, 3'd0, 32'h0000_0000);
    rd(S_STAT, 3'd1, 32'h0000_0000);

    // Register round trip
    wr(S_DDR, 3'd0, 32'hA5A5_5A5A);
    chk("ddr_w0_oe", oe[31:0], 32'hA5A5_5A5A);
    wr(S_DDR, 3'd1, 32'hFFFF_FFFF);
    chk("ddr_w1_oe", oe[35:32], 4'hF);
    rd(S_DDR, 3'd1, 32'h0000_000F);
    chk("rd_valid_pulse", rd_valid, 1);
    chk("rd_data_now", rd_data, 32'h0000_000F);
    tick(1);
    chk("rd_valid_drop", rd_valid, 0);
    chk("rd_data_hold", rd_data, 32'h0000_000F);
    wr(S_OD, 3'd0, 32'h1234_5678);
    chk("od_w0", od, 36'h0_1234_5678);
    wr(S_DATA, 3'd1, 32'hFFFF_FFF5);
    chk("out_w1", out_data, 36'h5_0000_0000);
    rd(S_OD, 3'd0, 32'h1234_5678);
    rd(S_DATA, 3'd1, 32'h0000_000F);

    // Falling edges on every pin latch status; irq masked off
    read_data = '0;
    tick(4);
    rd(S_STAT, 3'd0, 32'hFFFF_FFFF);
    rd(S_STAT, 3'd1, 32'h0000_000F);
    chk("irq_unmasked", irq, 0);
    wr(S_STAT, 3'd0, 32'hFFFF_FFFF);
    wr(S_STAT, 3'd1, 32'hFFFF_FFFF);
    rd(S_STAT, 3'd0, 32'h0000_0000);
    rd(S_STAT, 3'd1, 32'h0000_0000);

    // Input latency on pin 33
    read_data[33] = 1'b1;
    tick(1);
    rd(S_DATA, 3'd1, 32'h0000_0000);
    rd(S_DATA, 3'd1, 32'h0000_0002);
    tick(2);
    rd(S_STAT, 3'd1, 32'h0000_0002);
    wr(S_STAT, 3'd1, 32'h0000_0002);

    // Interrupt path on pin 0
    wr(S_MASK, 3'd0, 32'h0000_0001);
    rd(S_MASK, 3'd0, 32'h0000_0001);
    read_data[0] = 1'b1;
    tick(2);
    chk("irq_early", irq, 0);
    tick(1);
    chk("irq_rise", irq, 1);
    wr(S_STAT, 3'd0, 32'h0000_0001);
    chk("irq_clear", irq, 0);
    rd(S_STAT, 3'd0, 32'h0000_0000);

    // Set beats W1C on pin 4
    wr(S_MASK, 3'd0, 32'h0000_0010);
    read_data[4] = 1'b1;
    tick(2);
    wr(S_STAT, 3'd0, 32'h0000_0010);
    chk("collide_irq", irq, 1);
    rd(S_STAT, 3'd0, 32'h0000_0010);
    wr(S_STAT, 3'd0, 32'h0000_0010);
    chk("collide_clear_irq", irq, 0);
    rd(S_STAT, 3'd0, 32'h0000_0000);

    // Same-cycle read and write returns the old value
    rdwr(S_DDR, 3'd0, 32'h0000_0055, 32'hA5A5_5A5A);
    rd(S_DDR, 3'd0, 32'h0000_0055);

    // Asynchronous reset mid-cycle
    wr(S_DDR, 3'd0, 32'hFFFF_FFFF);
    chk("oe_all", oe, 36'hF_FFFF_FFFF);
    #3 reset_n = 1'b0;
    #1;
    chk("async_oe", oe, 0);
    chk("async_od", od, 0);
    chk("async_out", out_data, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(4);

    // Out-of-range word and reserved select
    wr(S_DDR, 3'd2, 32'hFFFF_FFFF);
    wr(S_RSVD, 3'd0, 32'hFFFF_FFFF);
    wr(S_OD, 3'd3, 32'hFFFF_FFFF);
    chk("bound_oe", oe, 0);
    chk("bound_od", od, 0);
    chk("bound_out", out_data, 0);
    rd(S_DDR, 3'd2, 32'h0000_0000);
    rd(S_RSVD, 3'd0, 32'h0000_0000);
    rd(S_DDR, 3'd0, 32'h0000_0000);
    rd(S_STAT, 3'd0, 32'h0000_0000);
    rd(S_STAT, 3'd1, 32'h0000_0000);

    tick(3);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
